register_bank: RTL



---
 rtl/register_bank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// RV32I architectural register file: writeback commit port, two bypassed decode read ports and a
// per-register in-flight write scoreboard that drives the decode stall.
module register_bank #(
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          CntWidth  = 2,
   parameter logic [DataWidth-1:0] SpInit    = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   // Decode read ports
   input  logic [4:0]           rs1_addr_i,
   input  logic [4:0]           rs2_addr_i,
   input  logic                 rs1_used_i,
   input  logic                 rs2_used_i,
   output logic [DataWidth-1:0] rs1_data_o,
   output logic [DataWidth-1:0] rs2_data_o,
   // Decode issue
   input  logic                 issue_valid_i,
   input  logic                 issue_reg_write_i,
   input  logic [4:0]           issue_reg_dest_i,
   output logic                 stall_o,
   // Writeback commit
   input  logic                 rb_write_en_i,
   input  logic                 in_reg_write_i,
   input  logic [4:0]           in_reg_dest_i,
   input  logic [DataWidth-1:0] data_wb_i,
   // Control and status
   input  logic                 flush_i,
   output logic [31:0]          busy_mask_o,
   output logic                 sb_error_o
);

   localparam logic [CntWidth-1:0] CntMax  = '1;
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
   localparam logic [CntWidth-1:0] CntZero = '0;

   logic [DataWidth-1:0] regs_q [32];
   logic [CntWidth-1:0]  cnt_q  [32];
   logic [CntWidth-1:0]  cnt_d  [32];
   logic [CntWidth-1:0]  eff    [32];
   logic                 sb_error_q, sb_error_d;

   logic        commit;
   logic        accept;
   logic        hazard_rs1, hazard_rs2, dest_full;
   logic [31:0] retire_vec;
   logic [31:0] accept_vec;
   logic [31:0] err_hit;

   // A retire this cycle already frees its slot for the issue/stall decision.
   always_comb begin
      commit     = rb_write_en_i && in_reg_write_i && (in_reg_dest_i != 5'd0);
      retire_vec = commit ? (32'd1 << in_reg_dest_i) : 32'd0;
      for (int i = 0; i < 32; i++) begin
         eff[i] = (retire_vec[i] && (cnt_q[i] != CntZero)) ? cnt_q[i] - CntOne : cnt_q[i];
      end
   end

   always_comb begin
      if (rs1_addr_i == 5'd0) begin
         rs1_data_o = '0;
      end else if (commit && (in_reg_dest_i == rs1_addr_i)) begin
         rs1_data_o = data_wb_i;
      end else begin
         rs1_data_o = regs_q[rs1_addr_i];
      end

      if (rs2_addr_i == 5'd0) begin
         rs2_data_o = '0;
      end else if (commit && (in_reg_dest_i == rs2_addr_i)) begin
         rs2_data_o = data_wb_i;
      end else begin
         rs2_data_o = regs_q[rs2_addr_i];
      end
   end

   always_comb begin
      hazard_rs1 = rs1_used_i && (eff[rs1_addr_i] != CntZero);
      hazard_rs2 = rs2_used_i && (eff[rs2_addr_i] != CntZero);
      dest_full  = issue_reg_write_i && (issue_reg_dest_i != 5'd0) &&
                   (eff[issue_reg_dest_i] == CntMax);
      stall_o    = issue_valid_i && !flush_i && (hazard_rs1 || hazard_rs2 || dest_full);
      accept     = issue_valid_i && !stall_o && !flush_i && issue_reg_write_i &&
                   (issue_reg_dest_i != 5'd0);
      accept_vec = accept ? (32'd1 << issue_reg_dest_i) : 32'd0;
   end

   always_comb begin
      err_hit = '0;
      for (int i = 0; i < 32; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush_i) begin
            cnt_d[i] = CntZero;
         end else if (accept_vec[i] && retire_vec[i]) begin
            cnt_d[i] = cnt_q[i];
         end else if (accept_vec[i]) begin
            cnt_d[i] = cnt_q[i] + CntOne;
         end else if (retire_vec[i]) begin
            if (cnt_q[i] == CntZero) begin
               err_hit[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - CntOne;
            end
         end
      end
      cnt_d[0]   = CntZero;
      sb_error_d = sb_error_q || (|err_hit);
   end

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         busy_mask_o[i] = (cnt_q[i] != CntZero);
      end
   end

   assign sb_error_o = sb_error_q;

   // Register data commits even during flush; x0 is never written since commit excludes it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= (i == 2) ? SpInit : '0;
            cnt_q[i]  <= CntZero;
         end
         sb_error_q <= 1'b0;
      end else begin
         if (commit) begin
            regs_q[in_reg_dest_i] <= data_wb_i;
         end
         cnt_q      <= cnt_d;
         sb_error_q <= sb_error_d;
      end
   end

endmodule
